issue_controller: RTL and testbench

- Sits between the Fetcher and the combinational Decoder; owns a small instruction queue (IQ) and decides each cycle whether the head instruction may be issued.
- Issue is gated by ReorderBuffer space and by space in the target unit: LoadStoreBuffer for load/store opcodes, ReservationStation for everything else.
- Flushes on ROB rollback (mispredict) so no wrong-path instruction reaches the Decoder.

---
 rtl/issue_controller_pkg.sv | 49 ++++
 rtl/issue_controller_inst_queue.sv | 51 +++++
 rtl/issue_controller.sv | 82 ++++++++
 tb/tb_issue_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_controller_pkg.sv
// Shared types and constants for the issue controller slice.
// Opcode map, entry bundle and head classification helper.
package issue_controller_pkg;

    localparam int INSTRUCTION_MSB = 31;
    localparam int WORD_MSB = 31;
    localparam int IQ_DEPTH_DEFAULT = 4;

    typedef logic [INSTRUCTION_MSB:0] inst_t;
    typedef logic [WORD_MSB:0] word_t;

    localparam word_t ZERO_WORD = '0;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH = 7'b0110011;

    typedef enum logic [1:0] {
        TGT_RS,
        TGT_LSB,
        TGT_ILLEGAL
    } target_e;

    typedef struct packed {
        inst_t inst;
        word_t pc;
    } iq_entry_t;

    function automatic target_e classify(input logic [6:0] opcode);
        target_e t;
        t = TGT_ILLEGAL;
        unique case (opcode)
            OP_LOAD, OP_STORE: t = TGT_LSB;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_BRANCH, OP_ARITH_IMM, OP_ARITH: t = TGT_RS;
            default: t = TGT_ILLEGAL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/issue_controller_inst_queue.sv
// Circular instruction queue with push, pop and flush.
// Callers gate push/pop so overflow and underflow never occur.
module inst_queue
    import issue_controller_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int ADDR_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  iq_entry_t       push_data,
    output iq_entry_t       head_data,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            empty
);

    iq_entry_t mem [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; count gates every read of stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[tail] <= push_data;
    end

    assign head_data = mem[head];
    assign full = (count == (ADDR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/issue_controller.sv
// Head classification and issue gating between Fetcher and Decoder.
// Illegal heads are dropped; rollback empties the queue.
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter int IQ_ADDR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_in,
    input  logic               fet_valid_in,
    input  logic [31:0]        fet_inst_in,
    input  logic [31:0]        fet_pc_in,
    output logic               fet_ready_out,
    output logic               dec_issue_out,
    output logic [31:0]        dec_inst_out,
    output logic [31:0]        dec_pc_out,
    input  logic               rob_full_in,
    input  logic               rs_full_in,
    input  logic               lsb_full_in,
    input  logic               rob_rollback_in,
    output logic [IQ_ADDR_W:0] iq_count_out
);

    iq_entry_t push_data;
    iq_entry_t head;
    logic q_full;
    logic q_empty;
    logic push;
    logic pop;
    logic flush;
    logic drop;
    logic can_issue;
    logic target_full;
    target_e target;

    assign push_data = '{inst: fet_inst_in, pc: fet_pc_in};
    assign target = classify(head.inst[6:0]);

    always_comb begin
        target_full = FALSE;
        unique case (1'b1)
            target == TGT_LSB: target_full = lsb_full_in;
            target == TGT_RS: target_full = rs_full_in;
            default: target_full = FALSE;
        endcase
    end

    assign can_issue = rdy_in & !q_empty & !rob_rollback_in
                     & !rob_full_in & !target_full
                     & (target != TGT_ILLEGAL);
    assign drop = rdy_in & !q_empty & !rob_rollback_in
                & (target == TGT_ILLEGAL);

    assign push = rdy_in & fet_valid_in & !q_full & !rob_rollback_in;
    assign pop = can_issue | drop;
    assign flush = rdy_in & rob_rollback_in;

    inst_queue #(
        .DEPTH(IQ_DEPTH),
        .ADDR_W(IQ_ADDR_W)
    ) u_iq (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(flush),
        .push_data(push_data),
        .head_data(head),
        .count(iq_count_out),
        .full(q_full),
        .empty(q_empty)
    );

    // Ready comes from registered occupancy only.
    assign fet_ready_out = !q_full;
    assign dec_issue_out = can_issue;
    assign dec_inst_out = q_empty ? ZERO_WORD : head.inst;
    assign dec_pc_out = q_empty ? ZERO_WORD : head.pc;

endmodule

// File: tb/tb_issue_controller.sv
// Scenario bench for issue_controller; a negedge monitor
// checks every issue against the expected-order queue.
module tb_issue_controller;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fet_valid;
    logic [31:0] fet_inst;
    logic [31:0] fet_pc;
    logic        fet_ready;
    logic        dec_issue;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        rollback;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb [$];

    issue_controller #(.IQ_DEPTH(4), .IQ_ADDR_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .rdy_in(rdy),
        .fet_valid_in(fet_valid),
        .fet_inst_in(fet_inst),
        .fet_pc_in(fet_pc),
        .fet_ready_out(fet_ready),
        .dec_issue_out(dec_issue),
        .dec_inst_out(dec_inst),
        .dec_pc_out(dec_pc),
        .rob_full_in(rob_full),
        .rs_full_in(rs_full),
        .lsb_full_in(lsb_full),
        .rob_rollback_in(rollback),
        .iq_count_out(count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && dec_issue === 1'b1) begin
            logic [63:0] e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected got inst=%h pc=%h want none",
                         dec_inst, dec_pc);
            end else begin
                e = sb.pop_front();
                if ({dec_inst, dec_pc} !== e) begin
                    n_err++;
                    $display("FAIL issue_order got %h/%h want %h/%h",
                             dec_inst, dec_pc, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fet(input logic v, input logic [31:0] i,
                       input logic [31:0] p);
        fet_valid = v;
        fet_inst = i;
        fet_pc = p;
    endtask

    function automatic logic [31:0] addi(input int k);
        logic [11:0] imm;
        imm = 12'(k + 1);
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        n_cmp++;
        if (dec_issue !== 1'b0) begin
            n_err++;
            $display("FAIL reset_issue got %b want 0", dec_issue);
        end
        n_cmp++;
        if (dec_inst !== 32'h0 || dec_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h want 0/0", dec_inst, dec_pc);
        end
        n_cmp++;
        if (fet_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got %b want 1", fet_ready);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_count got %0d want 0", count);
        end
    endtask

    task automatic test_basic();
        fet(1, 32'h00500093, 32'h0);
        sb.push_back({32'h00500093, 32'h0});
        #1;
        n_cmp++;
        if (dec_issue !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty_issue got %b want 0", dec_issue);
        end
        step();
        fet(0, 0, 0);
        #1;
        n_cmp++;
        if (dec_issue !== 1'b1 || dec_inst !== 32'h00500093) begin
            n_err++;
            $display("FAIL basic_issue got %b/%h want 1/00500093",
                     dec_issue, dec_inst);
        end
        step();
        #1;
        n_cmp++;
        if (count !== 3'd0 || dec_issue !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after got cnt=%0d iss=%b want 0/0",
                     count, dec_issue);
        end
    endtask

    task automatic test_stall();
        lsb_full = 1;
        fet(1, 32'h0000a103, 32'h4);
        sb.push_back({32'h0000a103, 32'h4});
        step();
        fet(1, 32'h002081b3, 32'h8);
        sb.push_back({32'h002081b3, 32'h8});
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (dec_issue !== 1'b0 || dec_inst !== 32'h0000a103) begin
                n_err++;
                $display("FAIL stall_hold c=%0d got %b/%h want 0/0000a103",
                         c, dec_issue, dec_inst);
            end
            step();
            fet(0, 0, 0);
        end
        lsb_full = 0;
        #1;
        n_cmp++;
        if (dec_issue !== 1'b1 || dec_pc !== 32'h4) begin
            n_err++;
            $display("FAIL stall_release got %b/%h want 1/4", dec_issue, dec_pc);
        end
        step();
        #1;
        n_cmp++;
        if (dec_issue !== 1'b1 || dec_pc !== 32'h8) begin
            n_err++;
            $display("FAIL stall_next got %b/%h want 1/8", dec_issue, dec_pc);
        end
        step();
    endtask

    task automatic test_full();
        rob_full = 1;
        for (int i = 0; i < 4; i++) begin
            fet(1, addi(i), 32'h100 + 32'(4 * i));
            sb.push_back({addi(i), 32'h100 + 32'(4 * i)});
            step();
        end
        fet(1, 32'h00000013, 32'h1f0);
        #1;
        n_cmp++;
        if (count !== 3'd4 || fet_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_state got cnt=%0d rdy=%b want 4/0",
                     count, fet_ready);
        end
        step();
        fet(0, 0, 0);
        rob_full = 0;
        #1;
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL full_refuse got cnt=%0d want 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dec_issue !== 1'b1 || dec_inst !== addi(i)
                || dec_pc !== 32'h100 + 32'(4 * i)) begin
                n_err++;
                $display("FAIL full_drain i=%0d got %b/%h/%h want 1/%h/%h",
                         i, dec_issue, dec_inst, dec_pc,
                         addi(i), 32'h100 + 32'(4 * i));
            end
            step();
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL full_empty got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_push_pop();
        rob_full = 1;
        for (int i = 0; i < 3; i++) begin
            fet(1, addi(10 + i), 32'h300 + 32'(4 * i));
            sb.push_back({addi(10 + i), 32'h300 + 32'(4 * i)});
            step();
        end
        rob_full = 0;
        fet(1, addi(13), 32'h30c);
        sb.push_back({addi(13), 32'h30c});
        #1;
        n_cmp++;
        if (count !== 3'd3 || dec_issue !== 1'b1 || dec_pc !== 32'h300) begin
            n_err++;
            $display("FAIL pp_issue got cnt=%0d %b/%h want 3/1/300",
                     count, dec_issue, dec_pc);
        end
        step();
        fet(0, 0, 0);
        n_cmp++;
        if (count !== 3'd3) begin
            n_err++;
            $display("FAIL pp_count got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL pp_drain got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_rollback();
        rob_full = 1;
        for (int i = 0; i < 3; i++) begin
            fet(1, addi(20 + i), 32'h400 + 32'(4 * i));
            step();
        end
        rob_full = 0;
        rollback = 1;
        fet(1, addi(23), 32'h40c);
        #1;
        n_cmp++;
        if (dec_issue !== 1'b0 || count !== 3'd3) begin
            n_err++;
            $display("FAIL rb_issue got %b cnt=%0d want 0/3", dec_issue, count);
        end
        step();
        rollback = 0;
        fet(0, 0, 0);
        #1;
        n_cmp++;
        if (count !== 3'd0 || fet_ready !== 1'b1 || dec_issue !== 1'b0
            || dec_inst !== 32'h0) begin
            n_err++;
            $display("FAIL rb_after got cnt=%0d rdy=%b iss=%b inst=%h want 0/1/0/0",
                     count, fet_ready, dec_issue, dec_inst);
        end
        step();
    endtask

    task automatic test_illegal();
        fet(1, 32'h0000007f, 32'h500);
        step();
        fet(1, 32'h00500093, 32'h504);
        sb.push_back({32'h00500093, 32'h504});
        #1;
        n_cmp++;
        if (dec_issue !== 1'b0 || dec_inst !== 32'h0000007f) begin
            n_err++;
            $display("FAIL ill_drop got %b/%h want 0/0000007f",
                     dec_issue, dec_inst);
        end
        step();
        fet(0, 0, 0);
        #1;
        n_cmp++;
        if (dec_issue !== 1'b1 || dec_pc !== 32'h504 || count !== 3'd1) begin
            n_err++;
            $display("FAIL ill_next got %b/%h cnt=%0d want 1/504/1",
                     dec_issue, dec_pc, count);
        end
        step();
    endtask

    task automatic test_rdy();
        rob_full = 1;
        fet(1, addi(30), 32'h600);
        sb.push_back({addi(30), 32'h600});
        step();
        fet(1, addi(31), 32'h604);
        sb.push_back({addi(31), 32'h604});
        step();
        rob_full = 0;
        rdy = 0;
        fet(1, addi(32), 32'h608);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (dec_issue !== 1'b0 || count !== 3'd2 || dec_pc !== 32'h600
                || fet_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rdy_freeze c=%0d got %b cnt=%0d pc=%h rdy=%b",
                         c, dec_issue, count, dec_pc, fet_ready);
            end
            step();
        end
        rdy = 1;
        fet(0, 0, 0);
        #1;
        n_cmp++;
        if (dec_issue !== 1'b1 || dec_pc !== 32'h600) begin
            n_err++;
            $display("FAIL rdy_resume got %b/%h want 1/600", dec_issue, dec_pc);
        end
        step();
        step();
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL rdy_drain got cnt=%0d want 0", count);
        end
    endtask

    initial begin
        rst = 1;
        rdy = 1;
        rob_full = 0;
        rs_full = 0;
        lsb_full = 0;
        rollback = 0;
        fet(0, 0, 0);
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_push_pop();
        test_rollback();
        test_illegal();
        test_rdy();
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
